des_mask_counter_array: RTL

Multi-mask linear-approximation counter that sits beside the pipelined DES core in each DES block. It takes the plaintext stream entering the DES pipeline and the ciphertext stream leaving it. For each of N_MASKS run-time mask pairs it counts how many plaintext/ciphertext pairs satisfy parity(P & mask_i) ^ parity(C & mask_o) = 1. A parity FIFO replaces the fixed shift buffer of the previous generation, so the DES pipeline may pause, stall or run at any depth up to FIFO_DEPTH-1.

---
 rtl/des_mask_counter_array.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/des_mask_counter_array.sv
// des_mask_counter_array
// Counts, for each of N_MASKS run-time mask pairs, the plaintext/ciphertext
// pairs that satisfy parity(P & mask_i) ^ parity(C & mask_o) = 1.
// Input-side parities wait in a FIFO until the DES pipeline delivers the
// matching ciphertext, so the pipeline may stall or change depth freely.
// Optional feature macro: DES_MASK_CNT_SAT_EN (saturate counters instead of wrap).
module des_mask_counter_array #(
  parameter int N_MASKS    = 4,
  parameter int COUNT_W    = 48,
  parameter int FIFO_DEPTH = 32,
  localparam int SEL_W     = (N_MASKS > 1) ? $clog2(N_MASKS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    abort,
  input  logic [64*N_MASKS-1:0]   mask_i,
  input  logic [64*N_MASKS-1:0]   mask_o,
  input  logic                    msg_valid,
  input  logic [63:0]             msg,
  input  logic                    msg_last,
  input  logic                    ct_valid,
  input  logic [63:0]             ct,
  input  logic [SEL_W-1:0]        rd_sel,
  output logic [COUNT_W-1:0]      rd_count,
  output logic [N_MASKS-1:0]      overflow,
  output logic                    fifo_err,
  output logic                    busy,
  output logic                    done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(FIFO_DEPTH);
  localparam logic [SEL_W:0] N_SEL = (SEL_W + 1)'(N_MASKS);
  localparam logic [COUNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, next_state;

  logic [64*N_MASKS-1:0] mask_i_reg, mask_o_reg;
  logic [N_MASKS-1:0]    fifo_mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           fifo_cnt;
  logic [COUNT_W-1:0]    counters [N_MASKS];

  logic               active, start_go;
  logic               fifo_empty, fifo_full;
  logic               push_req, pop_req, do_push, do_pop;
  logic               underflow, push_drop;
  logic [N_MASKS-1:0] push_par, pop_par, hit;

  // Abort wins over everything, so no FIFO or counter activity happens on an abort cycle.
  assign active     = (state == RUN || state == DRAIN) && !abort;
  assign start_go   = start && !abort && (state == IDLE || state == DONE);
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == FULL_CNT);
  assign push_req   = active && (state == RUN) && msg_valid;
  assign pop_req    = active && ct_valid;
  assign do_pop     = pop_req && !fifo_empty;
  assign do_push    = push_req && (!fifo_full || do_pop);
  assign underflow  = pop_req && fifo_empty;
  assign push_drop  = push_req && fifo_full && !do_pop;
  assign pop_par    = fifo_mem[rd_ptr];
  assign busy       = (state == RUN || state == DRAIN);
  assign done       = (state == DONE);

  // Per-mask parities of the incoming plaintext and hit detection for the outgoing ciphertext.
  always_comb begin
    push_par = '0;
    hit      = '0;
    for (int k = 0; k < N_MASKS; k++) begin
      push_par[k] = ^(msg & mask_i_reg[64*k +: 64]);
      hit[k]      = pop_par[k] ^ (^(ct & mask_o_reg[64*k +: 64]));
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Next-state logic; a run ends once the FIFO is empty and no ciphertext is arriving.
  always_comb begin
    next_state = state;
    if (abort) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE, DONE: if (start) next_state = RUN;
        RUN:        if (msg_valid && msg_last) next_state = DRAIN;
        DRAIN:      if (fifo_empty && !ct_valid) next_state = DONE;
        default:    next_state = IDLE;
      endcase
    end
  end

  // Masks are captured only when a run starts, so port changes mid-run have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mask_i_reg <= '0;
      mask_o_reg <= '0;
    end else if (start_go) begin
      mask_i_reg <= mask_i;
      mask_o_reg <= mask_o;
    end
  end

  // Parity FIFO storage; a full FIFO with a simultaneous pop overwrites the slot being read.
  always_ff @(posedge clk) begin
    if (do_push) fifo_mem[wr_ptr] <= push_par;
  end

  // FIFO pointers and occupancy; cleared on start and flushed on abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else if (start_go || abort) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   fifo_cnt <= fifo_cnt + (AW + 1)'(1);
        2'b01:   fifo_cnt <= fifo_cnt - (AW + 1)'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
    end
  end

  // Sticky FIFO error flag; survives abort for post-mortem readout.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                         fifo_err <= 1'b0;
    else if (start_go)               fifo_err <= 1'b0;
    else if (underflow || push_drop) fifo_err <= 1'b1;
  end

  // Hit counters with sticky overflow flags; held across abort until the next start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < N_MASKS; k++) counters[k] <= '0;
      overflow <= '0;
    end else if (start_go) begin
      for (int k = 0; k < N_MASKS; k++) counters[k] <= '0;
      overflow <= '0;
    end else if (do_pop) begin
      for (int k = 0; k < N_MASKS; k++) begin
        if (hit[k]) begin
`ifdef DES_MASK_CNT_SAT_EN
          if (counters[k] == CNT_MAX) overflow[k] <= 1'b1;
          else                        counters[k] <= counters[k] + COUNT_W'(1);
`else
          if (counters[k] == CNT_MAX) overflow[k] <= 1'b1;
          counters[k] <= counters[k] + COUNT_W'(1);
`endif
        end
      end
    end
  end

  // Registered readout of the selected counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        rd_count <= '0;
    else if ({1'b0, rd_sel} < N_SEL) rd_count <= counters[rd_sel];
    else                            rd_count <= '0;
  end

endmodule
